// File: rtl/nibble_add_seq_pkg.sv
// Purpose: shared FSM encodings and digit-width constants for the nibble-serial adder.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package nibble_add_seq_pkg;

    // Width of one digit handled by the shared adder per cycle.
    localparam int NIBBLE_W = 4;

    // Sequencer states; the fourth encoding is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Digit index width: one extra bit over clog2 so the counter never wraps.
    function automatic int idx_width(input int nibbles);
        return $clog2(nibbles) + 1;
    endfunction

endpackage : nibble_add_seq_pkg

// File: rtl/four_fulladd.sv
// Purpose: 4-bit ripple-carry adder built from four full-adder cells.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module four_fulladd (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic       cout,
    output logic       s0,
    output logic       s1,
    output logic       s2,
    output logic       s3
);

    // Carry chain: c[0] is the carry-in, c[4] leaves the MSB cell.
    logic [4:0] c;

    assign c[0] = cin;

    assign s0   = a[0] ^ b[0] ^ c[0];
    assign c[1] = (a[0] & b[0]) | (a[0] & c[0]) | (b[0] & c[0]);

    assign s1   = a[1] ^ b[1] ^ c[1];
    assign c[2] = (a[1] & b[1]) | (a[1] & c[1]) | (b[1] & c[1]);

    assign s2   = a[2] ^ b[2] ^ c[2];
    assign c[3] = (a[2] & b[2]) | (a[2] & c[2]) | (b[2] & c[2]);

    assign s3   = a[3] ^ b[3] ^ c[3];
    assign c[4] = (a[3] & b[3]) | (a[3] & c[3]) | (b[3] & c[3]);

    assign cout = c[4];

endmodule : four_fulladd

// File: rtl/nibble_add_seq.sv
// Purpose: adds two W-bit operands one nibble per cycle through a single four_fulladd (optional ovf via OVERFLOW_FLAG_EN).
// Latency: res_valid rises exactly NIBBLES clocks after the start handshake.
// Backpressure: result held in DONE until res_ready; start_ready only in IDLE, so operations never overlap.
module nibble_add_seq
    import nibble_add_seq_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_valid,
    output logic                    start_ready,
    input  logic [4*NIBBLES-1:0]    a,
    input  logic [4*NIBBLES-1:0]    b,
    input  logic                    cin,
    output logic                    busy,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [4*NIBBLES-1:0]    sum,
    output logic                    cout
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic                    ovf
`endif
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_e           state_q;
    state_e           state_d;

    logic [W-1:0]     a_sh;
    logic [W-1:0]     b_sh;
    logic [W-1:0]     sum_sh;
    logic [W-1:0]     sum_sh_nxt;
    logic             carry;
    logic [IDX_W-1:0] idx;

    logic             start_fire;
    logic             res_fire;
    logic             last_digit;

    logic [3:0]       add_nib;
    logic             add_cout;
    logic             add_s0;
    logic             add_s1;
    logic             add_s2;
    logic             add_s3;

`ifdef OVERFLOW_FLAG_EN
    // Operand sign bits captured at acceptance; the shift registers lose them.
    logic             a_msb;
    logic             b_msb;
`endif

    // The single shared 4-bit adder, fed from the low nibble of each shifter.
    four_fulladd u_add (
        .a    (a_sh[3:0]),
        .b    (b_sh[3:0]),
        .cin  (carry),
        .cout (add_cout),
        .s0   (add_s0),
        .s1   (add_s1),
        .s2   (add_s2),
        .s3   (add_s3)
    );

    assign add_nib = {add_s3, add_s2, add_s1, add_s0};

    // New digit enters at the MSB end; after NIBBLES shifts the LSB digit sits at bit 0.
    assign sum_sh_nxt = W'({add_nib, sum_sh} >> NIBBLE_W);

    assign start_ready = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign res_valid   = (state_q == ST_DONE);

    assign start_fire  = start_valid && start_ready;
    assign res_fire    = res_valid && res_ready;
    assign last_digit  = (idx == LAST_IDX);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept in IDLE, count digits in RUN, wait for consumer in DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_fire) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_digit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_fire) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Operand shifters, carry and digit counter; load on accept, advance in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            idx    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_fire) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        idx   <= '0;
                    end
                end
                ST_RUN: begin
                    a_sh   <= a_sh >> NIBBLE_W;
                    b_sh   <= b_sh >> NIBBLE_W;
                    sum_sh <= sum_sh_nxt;
                    carry  <= add_cout;
                    idx    <= idx + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers: written only on the last digit, otherwise held (also across IDLE).
    always_ff @(posedge clk) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (state_q == ST_RUN && last_digit) begin
            sum  <= sum_sh_nxt;
            cout <= add_cout;
        end
    end

`ifdef OVERFLOW_FLAG_EN
    // Signed overflow: same-sign operands producing a result of the other sign.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
        end else if (start_fire) begin
            a_msb <= a[W-1];
            b_msb <= b[W-1];
        end else if (state_q == ST_RUN && last_digit) begin
            ovf   <= (a_msb == b_msb) && (sum_sh_nxt[W-1] != a_msb);
        end
    end
`endif

endmodule : nibble_add_seq

// File: tb/tb_nibble_add_seq.sv
// Purpose: directed self-checking bench for nibble_add_seq with NIBBLES=4 plus an arithmetic reference model.
// Latency: checks res_valid arrives 4 clocks after each accepted start.
// Backpressure: exercises held results, ignored starts in DONE, and reset mid-operation.
module tb_nibble_add_seq;

    localparam int N = 4;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_valid = 1'b0;
    logic         start_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
`ifdef OVERFLOW_FLAG_EN
    logic         ovf;
`endif

    int total = 0;
    int bad   = 0;

    nibble_add_seq #(.NIBBLES(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .cin         (cin),
        .busy        (busy),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .sum         (sum),
        .cout        (cout)
`ifdef OVERFLOW_FLAG_EN
        ,
        .ovf         (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference model: whole-word arithmetic, a pending result that matures N clocks after acceptance.
    bit           live = 0;
    bit           m_busy = 0;
    bit           m_valid = 0;
    int           m_remain = 0;
    logic [W-1:0] m_sum = '0;
    logic         m_cout = 1'b0;
    logic         m_ovf = 1'b0;
    logic [W-1:0] p_sum;
    logic         p_cout;
    logic         p_ovf;

    always @(posedge clk) begin
        if (rst) begin
            live = 1; m_busy = 0; m_valid = 0; m_remain = 0;
            m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
        end else if (live) begin
            if (!m_busy) begin
                if (start_valid) begin
                    {p_cout, p_sum} = {1'b0, a} + {1'b0, b} + 17'(cin);
                    p_ovf    = (a[W-1] == b[W-1]) && (p_sum[W-1] != a[W-1]);
                    m_busy   = 1;
                    m_remain = N;
                end
            end else if (m_remain > 0) begin
                m_remain--;
                if (m_remain == 0) begin
                    m_valid = 1; m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf;
                end
            end else if (res_ready) begin
                m_valid = 0;
                m_busy  = 0;
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (live) begin
            check("m.start_ready", start_ready, !m_busy);
            check("m.busy", busy, m_busy);
            check("m.res_valid", res_valid, m_valid);
            check("m.sum", sum, m_sum);
            check("m.cout", cout, m_cout);
`ifdef OVERFLOW_FLAG_EN
            check("m.ovf", ovf, m_ovf);
`endif
        end
    end

    // Present an operation at the current negedge; scramble inputs once accepted.
    task automatic start_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
        a = ia; b = ib; cin = ic; start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        a = ~ia; b = ia ^ ib; cin = ~ic;
    endtask

    // Bounded wait for res_valid; returns clocks since acceptance (20 means it never came).
    task automatic wait_result(output int lat);
        lat = 0;
        while (!res_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic take_result();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic ic, input logic [W-1:0] es, input logic ec);
        int lat;
        start_op(ia, ib, ic);
        wait_result(lat);
        check({tag, ".latency"}, lat, N);
        check({tag, ".sum"}, sum, es);
        check({tag, ".cout"}, cout, ec);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst.start_ready", start_ready, 1);
        check("rst.busy", busy, 0);
        check("rst.res_valid", res_valid, 0);
        check("rst.sum", sum, 0);
        check("rst.cout", cout, 0);
        rst = 1'b0;
        @(negedge clk);

        run_op("t5p8", 16'h0005, 16'h0008, 1'b1, 16'h000E, 1'b0);
        take_result();
        check("t5p8.idle", start_ready, 1);

        run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        take_result();
        run_op("cinrip", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
        take_result();

        // Consumer stalls in DONE while a new request is pressed.
        run_op("hold", 16'h00A5, 16'h0F0F, 1'b0, 16'h0FB4, 1'b0);
        a = 16'h1111; b = 16'h2222; cin = 1'b1; start_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold.sum", sum, 16'h0FB4);
            check("hold.start_ready", start_ready, 0);
            check("hold.res_valid", res_valid, 1);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        start_valid = 1'b0;
        check("hold.released", res_valid, 0);
        check("hold.idle", start_ready, 1);
        check("hold.sum_kept", sum, 16'h0FB4);
        @(negedge clk);

        // Reset during the second RUN cycle discards the operation.
        start_op(16'h1234, 16'h4321, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst.busy", busy, 0);
        check("mid_rst.res_valid", res_valid, 0);
        check("mid_rst.start_ready", start_ready, 1);
        check("mid_rst.sum", sum, 0);
        run_op("after_rst", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0);
        take_result();

        // Back-to-back operations.
        run_op("b2b1", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0);
        take_result();
        run_op("b2b2", 16'h9999, 16'h6667, 1'b0, 16'h0000, 1'b1);
        take_result();

`ifdef OVERFLOW_FLAG_EN
        run_op("ovf1", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0);
        check("ovf1.ovf", ovf, 1);
        take_result();
        run_op("ovf0", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        check("ovf0.ovf", ovf, 0);
        take_result();
`endif

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_nibble_add_seq
